// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths and the fetch FSM state type.
package pipe_pkg;

  localparam int ISIZE = 32;
  localparam int DSIZE = 32;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO with push/pop/flush and an occupancy output.
// Pointers carry one extra bit so full and empty are distinguishable.
// A push and a pop in the same cycle are legal at any occupancy.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Pointer and storage update; flush discards contents by realigning the pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign head_data = mem[rd_ptr[AW-1:0]];
  assign count     = wr_ptr - rd_ptr;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues one-cycle-latency reads to
// instruction memory and buffers returned instructions for decode.
// Optional feature macro: FETCH_BYPASS_EN (empty-FIFO response is presented
// to decode combinationally in its arrival cycle).
//
// Decode handshake: an instruction transfers in any cycle where
// if_valid=1 and if_ready=1. While if_valid=1 and if_ready=0 the if_* payload
// holds stable. if_valid is forced low during a redirect, so nothing
// transfers in that cycle.
module fetch_queue #(
  parameter int                       ISIZE    = pipe_pkg::ISIZE,
  parameter int                       DSIZE    = pipe_pkg::DSIZE,
  parameter int                       DEPTH    = 4,
  parameter logic [ISIZE-1:0]         RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [ISIZE-1:0] imem_addr,
  input  logic [DSIZE-1:0] imem_data,
  input  logic             redirect_valid,
  input  logic [ISIZE-1:0] redirect_pc,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [DSIZE-1:0] if_inst,
  output logic [ISIZE-1:0] if_pc,
  output logic [ISIZE-1:0] if_pc_plus1,
  output logic             dbg_state
);

  import pipe_pkg::fetch_state_t, pipe_pkg::BOOT, pipe_pkg::RUN;

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  fetch_state_t           state;
  logic [ISIZE-1:0]       fetch_pc;
  logic [ISIZE-1:0]       tag_pc;
  logic                   inflight;
  logic [CW-1:0]          count;
  logic [DSIZE+ISIZE-1:0] head;
  logic                   resp_ok;
  logic                   push;
  logic                   pop;
  logic                   head_present;
  logic [CW:0]            credit_used;

  // A response is live only if no redirect kills it in its arrival cycle.
  assign resp_ok     = inflight & ~redirect_valid;
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_req    = (state == RUN) & (credit_used < DEPTH_C) & ~redirect_valid;
  assign imem_addr   = fetch_pc;
  assign dbg_state   = state;

`ifdef FETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit   = resp_ok & (count == '0);
  assign head_present = (count != '0) | bypass_hit;
  assign if_valid     = head_present & ~redirect_valid;
  assign if_inst      = bypass_hit ? imem_data : head[DSIZE+ISIZE-1:ISIZE];
  assign if_pc        = bypass_hit ? tag_pc    : head[ISIZE-1:0];
  assign push         = resp_ok & ~(bypass_hit & if_ready);
  assign pop          = if_valid & if_ready & ~bypass_hit;
`else
  assign head_present = (count != '0);
  assign if_valid     = head_present & ~redirect_valid;
  assign if_inst      = head[DSIZE+ISIZE-1:ISIZE];
  assign if_pc        = head[ISIZE-1:0];
  assign push         = resp_ok;
  assign pop          = if_valid & if_ready;
`endif

  // pc+1 for branch arithmetic; reads zero while no instruction is presented.
  assign if_pc_plus1 = head_present ? if_pc + 1'b1 : '0;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (DSIZE + ISIZE)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({imem_data, tag_pc}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head),
    .count     (count)
  );

  // FSM, fetch PC, request tag and in-flight tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     state <= RUN;
        default: state <= BOOT;
      endcase
      inflight <= imem_req;
      if (imem_req) begin
        tag_pc <= fetch_pc;
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: table-driven timeline after reset, hand-written
// stall / redirect / wrap / reset sequences, and a scoreboard that checks
// every instruction accepted by decode against the expected PC stream.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus1;
  logic        dbg_state;

  int checks;
  int errors;
  int n_pop;
  int n_req;

  logic [31:0] exp_q[$];

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_pc_plus1    (if_pc_plus1),
    .dbg_state      (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // instruction memory: one-cycle latency, returns addr + 0x100
  initial imem_data = '0;
  always @(posedge clk) begin
    if (imem_req) imem_data <= imem_addr + 32'h100;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic load_expected(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 64; k++) exp_q.push_back(start + 32'(k));
  endtask

  // driver: one cycle of inputs, applied at the falling edge
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst            = 1'b1;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (rv) load_expected(rpc);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("rst_req",   {31'b0, imem_req},  32'h0);
    check("rst_addr",  imem_addr,          32'h0);
    check("rst_valid", {31'b0, if_valid},  32'h0);
    check("rst_inst",  if_inst,            32'h0);
    check("rst_pc",    if_pc,              32'h0);
    check("rst_plus1", if_pc_plus1,        32'h0);
    check("rst_state", {31'b0, dbg_state}, 32'h0);
    load_expected(32'h0);
    @(negedge clk);
    @(negedge clk);
  endtask

  // scoreboard: every accepted instruction must match the head of exp_q
  always @(negedge clk) begin
    #2;
    if (rst && if_valid && if_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pop", if_pc, 32'hxxxxxxxx);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc",    if_pc,       e);
        check("sb_inst",  if_inst,     e + 32'h100);
        check("sb_plus1", if_pc_plus1, e + 32'h1);
      end
    end
  end

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    checks = 0; errors = 0; n_pop = 0; n_req = 0;
    rst = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // cycle-by-cycle timeline after reset release, decode always ready
    vecs[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h1, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h2, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h3, 1'b1, 32'h1};
    vecs[5] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h2};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].rdy, 1'b0, 32'h0);
      check($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc", i),   if_pc,   vecs[i].exp_pc);
        check($sformatf("vec%0d_inst", i), if_inst, vecs[i].exp_pc + 32'h100);
      end
    end

    // redirect in the same cycle decode is ready, head pc = 7
    repeat (4) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h80);
    check("redir_head_pc", if_pc,             32'h7);
    check("redir_valid",   {31'b0, if_valid}, 32'h0);
    check("redir_req",     {31'b0, imem_req}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("redir_r1_req",  {31'b0, imem_req}, 32'h1);
    check("redir_r1_addr", imem_addr,         32'h80);
    step(1'b1, 1'b0, 32'h0);
    check("redir_r2_valid", {31'b0, if_valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("redir_r3_valid", {31'b0, if_valid}, 32'h1);
    check("redir_r3_pc",    if_pc,             32'h80);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // fetch PC wrap
    step(1'b1, 1'b1, 32'hFFFFFFFF);
    step(1'b1, 1'b0, 32'h0);
    check("wrap_addr0", imem_addr, 32'hFFFFFFFF);
    step(1'b1, 1'b0, 32'h0);
    check("wrap_addr1", imem_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("wrap_pc",    if_pc,       32'hFFFFFFFF);
    check("wrap_plus1", if_pc_plus1, 32'h0);
    repeat (5) step(1'b1, 1'b0, 32'h0);

    // decode stalled: credit limit stops fetch after DEPTH requests
    do_reset();
    n_req = 0;
    for (int s = 0; s < 11; s++) begin
      step(1'b0, 1'b0, 32'h0);
      if (imem_req) begin
        check("stall_addr", imem_addr, 32'(n_req));
        n_req++;
      end
    end
    check("stall_req_count", 32'(n_req),        32'h4);
    check("stall_req_low",   {31'b0, imem_req}, 32'h0);
    check("stall_head_pc",   if_pc,             32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("resume_wait", {31'b0, imem_req}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("resume_req",  {31'b0, imem_req}, 32'h1);
    check("resume_addr", imem_addr,         32'h4);
    repeat (8) step(1'b1, 1'b0, 32'h0);

    // redirect with 3 buffered entries and 1 in flight
    do_reset();
    repeat (5) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h40);
    check("flush_valid", {31'b0, if_valid}, 32'h0);
    check("flush_req",   {31'b0, imem_req}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("flush_r1_addr",  imem_addr,         32'h40);
    check("flush_r1_valid", {31'b0, if_valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("flush_r2_valid", {31'b0, if_valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("flush_r3_pc", if_pc, 32'h40);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // back-to-back redirects: the last one wins
    step(1'b1, 1'b1, 32'h50);
    check("b2b_valid0", {31'b0, if_valid}, 32'h0);
    step(1'b1, 1'b1, 32'h60);
    check("b2b_valid1", {31'b0, if_valid}, 32'h0);
    check("b2b_req1",   {31'b0, imem_req}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("b2b_addr", imem_addr, 32'h60);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // reset while a request is in flight
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    check("mrst_boot_req",   {31'b0, imem_req}, 32'h0);
    check("mrst_boot_valid", {31'b0, if_valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("mrst_addr",   imem_addr,         32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("mrst_valid2", {31'b0, if_valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("mrst_pc",     if_pc,             32'h0);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    check("pops_seen", {31'b0, (n_pop > 20)}, 32'h1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end for the five-stage pipeline. Owns the program counter, issues word-addressed reads to the instruction memory (one-cycle read latency), and buffers returned instructions in a small FIFO. Presents them to the decode stage through a valid/ready handshake, so decode stalls no longer drop or replay fetches. Accepts a taken-branch redirect from execute, which flushes all younger work.

## Interface
- ISIZE, 32, PC width (word address)
- DSIZE, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  read strobe to instruction memory
- imem_addr  out  ISIZE  read address; valid while imem_req=1
- imem_data  in  DSIZE  read data, valid the cycle after imem_req
- redirect_valid  in  1  taken branch resolved in execute
- redirect_pc  in  ISIZE  branch target
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts this cycle
- if_inst  out  DSIZE  instruction at FIFO head
- if_pc  out  ISIZE  address of if_inst
- if_pc_plus1  out  ISIZE  if_pc+1, forwarded for branch-offset arithmetic

## Operation
- FSM states: BOOT, RUN. Reset → BOOT. BOOT lasts one cycle with imem_req=0, then RUN.
- RUN issue rule: imem_req=1 iff count + inflight < DEPTH and redirect_valid=0. count is the FIFO occupancy; inflight is 1 if a request was issued last cycle and not killed.
- On issue, fetch_pc ← fetch_pc+1, wrapping modulo 2^ISIZE. Each request carries its PC in a one-entry tag register.
- Response cycle: {imem_data, tag PC} is pushed unless the request was killed.
- Handshake: pop when if_valid & if_ready. Push and pop in the same cycle are legal at any occupancy, including full. Occupancy never exceeds DEPTH by construction.
- Redirect cycle:
  - FIFO flushed (count←0).
  - In-flight response marked killed.
  - if_valid forced 0, so no pop occurs.
  - imem_req=0.
  - fetch_pc ← redirect_pc.
  - The next cycle issues from redirect_pc.
- Back-to-back redirects: the last one wins; each cycle repeats the flush.
- if_ready=0 indefinitely: fetch stops once count+inflight=DEPTH and resumes the cycle after the first pop.
- Reset mid-operation: all state cleared asynchronously; no stale response is pushed after release.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_inst=0, if_pc=0, if_pc_plus1=0. Internal: fetch_pc=RESET_PC, count=0, inflight=0, state=BOOT.
- Latency, bypass off: request in cycle t → data pushed at end of t+1 → if_valid in t+2.
- Sustained throughput: one instruction per cycle while if_ready=1.
- Redirect asserted in cycle r: request for redirect_pc in r+1, if_valid for it in r+3 (r+2 with bypass).
- if_inst, if_pc and if_pc_plus1 hold stable while if_valid=1 and if_ready=0.

## Configuration
- FETCH_BYPASS_EN defined: when the FIFO is empty and a non-killed response arrives, the response drives if_* combinationally in its arrival cycle.
  - Accepted that cycle: it is not pushed.
  - Not accepted: it is pushed.
  - Latency is one cycle lower.
- Undefined: all instructions pass through FIFO storage; if_* are driven from registers only.

## Structure
- Shared package pipe_pkg: ISIZE, DSIZE constants; fetch_state_t enum {BOOT, RUN}.
- One sub-module, fetch_fifo:
  - Parameterised DEPTH-entry FIFO of {inst, pc} with push/pop/flush.
  - Occupancy output.
  - Pointers wrap modulo DEPTH, with one extra bit for full/empty.
- PC, credit, kill and FSM logic stay in fetch_queue.

## Test plan
- Reset release, if_ready=1, memory returns addr+0x100: if_valid first high 3 cycles after BOOT ends with inst=0x100, pc=0. Then one per cycle: pc 1, 2, 3…
- if_ready=0 for 10 cycles: exactly 4 requests issued (addr 0–3), imem_req then held low. Raising if_ready drains pc 0,1,2,3 in order and fetching resumes at 4.
- redirect_valid with redirect_pc=0x40 while FIFO holds 3 entries and 1 is in flight: none of those 4 appear on if_*. Next accepted pc=0x40, then 0x41.
- Redirect in the same cycle as if_ready=1 with head pc=7: pc 7 is not consumed (if_valid=0 that cycle). First accepted pc equals redirect_pc.
- fetch_pc=0xFFFFFFFF: next request address is 0x00000000 and if_pc_plus1 for that entry equals 0.
- rst asserted while a request is in flight, released 2 cycles later: no instruction from before the reset appears. First if_pc after release equals RESET_PC.
